// File: rtl/polinomio_horner.sv
// Polynomial evaluator using Horner's rule: one multiply-accumulate step per
// clock. Width, degree and signedness are parameters. A sticky overflow flag
// records whether any step's exact value fell outside the WIDTH-bit range.
module polinomio_horner #(
    parameter int WIDTH  = 16,
    parameter int DEGREE = 2,
    parameter int SIGNED = 0
) (
    input  logic                        ck,
    input  logic                        rst,
    input  logic                        inicio,
    input  logic [WIDTH-1:0]            X,
    input  logic [(DEGREE+1)*WIDTH-1:0] coefs,
    output logic [WIDTH-1:0]            Resultado,
    output logic                        pronto,
    output logic                        overflow,
    output logic                        ocupado
);

    localparam int IDX_W = $clog2(DEGREE + 1);
    // Exact width of acc*X + coef: 2*WIDTH for the product, plus one bit for the sum
    localparam int EXT_W = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_resultado;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_coef [0:DEGREE];
    logic               r_pronto;
    logic               r_overflow;

    logic [WIDTH-1:0]   w_coef_in [0:DEGREE];
    logic [WIDTH-1:0]   w_coef_sel;
    logic [EXT_W-1:0]   w_acc_ext;
    logic [EXT_W-1:0]   w_x_ext;
    logic [EXT_W-1:0]   w_coef_ext;
    logic [EXT_W-1:0]   w_prod;
    logic [EXT_W-1:0]   w_sum;
    logic               w_ovf;
    logic               w_sign_mode;

    // Split the flat coefficient bus into one word per power of X
    genvar gi;
    generate
        for (gi = 0; gi <= DEGREE; gi++) begin : g_coef_unpack
            assign w_coef_in[gi] = coefs[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_sign_mode = (SIGNED != 0);
    assign w_coef_sel  = r_coef[r_idx];

    // Extend operands to the exact-result width (sign- or zero-extension).
    // With both operands extended, the low EXT_W bits of the product are the
    // exact product in either mode, since that product always fits in EXT_W.
    assign w_acc_ext  = {{(WIDTH+1){w_sign_mode & r_acc[WIDTH-1]}}, r_acc};
    assign w_x_ext    = {{(WIDTH+1){w_sign_mode & r_x[WIDTH-1]}}, r_x};
    assign w_coef_ext = {{(WIDTH+1){w_sign_mode & w_coef_sel[WIDTH-1]}}, w_coef_sel};
    assign w_prod     = w_acc_ext * w_x_ext;
    assign w_sum      = w_prod + w_coef_ext;

    // Out of range: unsigned when any bit above WIDTH is set; signed when the
    // bits from the WIDTH-1 sign position upward are not all equal.
    assign w_ovf = w_sign_mode
                 ? !((&w_sum[EXT_W-1:WIDTH-1]) || !(|w_sum[EXT_W-1:WIDTH-1]))
                 : (|w_sum[EXT_W-1:WIDTH]);

    // Control FSM plus datapath registers: latch on start, one Horner step per cycle
    always_ff @(posedge ck) begin
        if (rst) begin
            r_state     <= OCIOSO;
            r_acc       <= '0;
            r_x         <= '0;
            r_idx       <= '0;
            r_resultado <= '0;
            r_pronto    <= 1'b0;
            r_overflow  <= 1'b0;
            for (int i = 0; i <= DEGREE; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            case (r_state)
                OCIOSO, FIM: begin
                    if (inicio) begin
                        r_x        <= X;
                        for (int i = 0; i <= DEGREE; i++) begin
                            r_coef[i] <= w_coef_in[i];
                        end
                        r_acc      <= w_coef_in[DEGREE];
                        r_idx      <= IDX_W'(DEGREE - 1);
                        r_overflow <= 1'b0;
                        r_pronto   <= 1'b0;
                        r_state    <= CALCULA;
                    end
                end
                CALCULA: begin
                    r_acc      <= w_sum[WIDTH-1:0];
                    r_overflow <= r_overflow | w_ovf;
                    if (r_idx == '0) begin
                        r_resultado <= w_sum[WIDTH-1:0];
                        r_pronto    <= 1'b1;
                        r_state     <= FIM;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                default: r_state <= OCIOSO;
            endcase
        end
    end

    assign Resultado = r_resultado;
    assign pronto    = r_pronto;
    assign overflow  = r_overflow;
    assign ocupado   = (r_state == CALCULA);

endmodule
